// File: rtl/bridge_rr_arbiter_pkg.sv
// Shared types for the bridge command-port arbiter: FSM encodings, the
// pending-slot record and a small modulo helper used by the picker and the FSM.
package bridge_rr_arbiter_pkg;

  localparam int SLOT_ADDR_W = 8;
  localparam int SLOT_DATA_W = 32;

  typedef enum logic [2:0] {
    AXI_IDLE,
    AXI_AW_W,
    AXI_B,
    AXI_AR,
    AXI_R
  } axi_stage_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic                   r_wb;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [SLOT_DATA_W-1:0] data_w;
  } slot_t;

  // Single-step wrap: callers never pass more than 2*n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/bridge_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_pending at or above
// i_rr_ptr, wrapping modulo NUM_REQ.
module bridge_rr_arbiter_rr_pick
  import bridge_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_found
);

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_pending[IDX_W'(rr_wrap(int'(i_rr_ptr) + k, NUM_REQ))]) begin
        o_grant = IDX_W'(rr_wrap(int'(i_rr_ptr) + k, NUM_REQ));
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_rr_arbiter.sv
// Round-robin sharing of the bridge command port among NUM_REQ requesters,
// one outstanding bridge transaction at a time.
//   state | meaning
//   IDLE  | pick next pending slot from rr_ptr
//   ISSUE | C_in_valid pulse with the granted slot's command
//   WAIT  | wait for C_out_valid, latch C_data_r
//   RESP  | rsp_valid to owner, free slot, advance rr_ptr
module bridge_rr_arbiter
  import bridge_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SLOT_ADDR_W,
  parameter int DATA_W  = SLOT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_r_wb,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_w,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      C_in_valid,
  output logic                      C_r_wb,
  output logic [ADDR_W-1:0]         C_addr,
  output logic [DATA_W-1:0]         C_data_w,
  input  logic                      C_out_valid,
  input  logic [DATA_W-1:0]         C_data_r
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  slot_t              r_slot [NUM_REQ];
  logic [NUM_REQ-1:0] r_busy;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_grant;
  logic               w_found;

  assign req_busy = r_busy;

  // Picking only happens in IDLE, when nothing is in flight, so every busy
  // slot is a pending one.
  bridge_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_pending (r_busy),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_grant),
    .o_found   (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_busy     <= '0;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      C_in_valid <= 1'b0;
      C_r_wb     <= 1'b0;
      C_addr     <= '0;
      C_data_w   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      C_in_valid <= 1'b0;
      rsp_valid  <= '0;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !r_busy[i]) begin
          r_busy[i]        <= 1'b1;
          r_slot[i].r_wb   <= req_r_wb[i];
          r_slot[i].addr   <= req_addr[i*ADDR_W +: ADDR_W];
          r_slot[i].data_w <= req_data_w[i*DATA_W +: DATA_W];
        end
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant    <= w_grant;
            C_in_valid <= 1'b1;
            C_r_wb     <= r_slot[w_grant].r_wb;
            C_addr     <= r_slot[w_grant].addr;
            C_data_w   <= r_slot[w_grant].data_w;
            r_state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: r_state <= ARB_WAIT;
        ARB_WAIT: begin
          if (C_out_valid) begin
            rsp_data           <= C_data_r;
            rsp_valid[r_grant] <= 1'b1;
            r_state            <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          r_busy[r_grant] <= 1'b0;
          r_rr_ptr        <= IDX_W'(rr_wrap(int'(r_grant) + 1, NUM_REQ));
          r_state         <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_rr_arbiter.sv
// Scoreboard bench for bridge_rr_arbiter with a behavioural bridge model.
module tb_bridge_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_r_wb;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data_w;
  logic [N-1:0]    req_busy;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            C_in_valid;
  logic            C_r_wb;
  logic [AW-1:0]   C_addr;
  logic [DW-1:0]   C_data_w;
  logic            C_out_valid = 1'b0;
  logic [DW-1:0]   C_data_r    = '0;

  bridge_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_r_wb    (req_r_wb),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_busy    (req_busy),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rwb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t mon_c;
  rsp_t mon_r;
  int   total = 0;
  int   bad = 0;
  int   outstanding = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bridge model: fixed latency; reads return DEADBEEF at 3C else A5A5A5_addr,
  // writes return B_RESP 2 (SLVERR) at EE else 0.
  int            bridge_lat = 5;
  int            b_cnt = 0;
  bit            b_busy = 1'b0;
  logic [DW-1:0] b_res = '0;
  int            spur_cnt = 0;
  int            spur_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_busy      = 1'b0;
      C_out_valid = 1'b0;
    end else begin
      C_out_valid = 1'b0;
      if (b_busy) begin
        b_cnt--;
        if (b_cnt == 0) begin
          b_busy      = 1'b0;
          C_out_valid = 1'b1;
          C_data_r    = b_res;
        end
      end else if (spur_done != spur_cnt) begin
        spur_done++;
        C_out_valid = 1'b1;
        C_data_r    = 32'hBAD0_BAD0;
      end
      if (C_in_valid) begin
        b_busy = 1'b1;
        b_cnt  = bridge_lat;
        if (C_r_wb) b_res = (C_addr == 8'h3C) ? 32'hDEAD_BEEF : {24'hA5A5A5, C_addr};
        else        b_res = (C_addr == 8'hEE) ? 32'd2 : 32'd0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a command or response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (C_in_valid) begin
        chk("one_outstanding", outstanding, 0);
        outstanding = 1;
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got addr %h expected none", C_addr);
        end else begin
          mon_c = cmd_q.pop_front();
          chk("cmd_r_wb", C_r_wb, mon_c.rwb);
          chk("cmd_addr", C_addr, mon_c.addr);
          chk("cmd_data_w", C_data_w, mon_c.data);
        end
      end
      if (rsp_valid != '0) begin
        outstanding = 0;
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_valid", rsp_valid, mon_r.vld);
          chk("rsp_data", rsp_data, mon_r.data);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_r_wb[i]           = rwb;
    req_addr[i*AW +: AW]  = a;
    req_data_w[i*DW +: DW] = d;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk);
    req_valid = m;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic expect_txn(input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [N-1:0] vld, input logic [DW-1:0] rd);
    cmd_q.push_back('{rwb, a, d});
    rsp_q.push_back('{vld, rd});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0 || req_busy != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_queued_left"}, cmd_q.size() + rsp_q.size(), 0);
    chk({name, "_busy_left"}, req_busy, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rsp(input string name, input logic [N-1:0] m, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((rsp_valid & m) == '0) && n < budget);
    chk({name, "_rsp_seen"}, ((rsp_valid & m) != '0), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_busy"}, req_busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_C_in_valid"}, C_in_valid, 0);
    chk({tag, "_C_r_wb"}, C_r_wb, 0);
    chk({tag, "_C_addr"}, C_addr, 0);
    chk({tag, "_C_data_w"}, C_data_w, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    outstanding = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_r_wb   = '0;
    req_addr   = '0;
    req_data_w = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #1 rst_n = 1'b1;

    // Single read by requester 0; busy clears the cycle after rsp_valid.
    set_req(0, 1'b1, 8'h3C, 32'h0);
    expect_txn(1'b1, 8'h3C, 32'h0, 4'b0001, 32'hDEAD_BEEF);
    pulse(4'b0001);
    wait_rsp("single_read", 4'b0001, 40);
    chk("busy0_during_resp", req_busy[0], 1);
    @(negedge clk);
    chk("busy0_after_resp", req_busy[0], 0);
    wait_drain("single_read", 40);

    // Single write by requester 2 (rr_ptr = 1).
    set_req(2, 1'b0, 8'h05, 32'h1234_5678);
    expect_txn(1'b0, 8'h05, 32'h1234_5678, 4'b0100, 32'h0);
    pulse(4'b0100);
    wait_drain("single_write", 40);

    // Simultaneous requests from rr_ptr = 0: grants 0,1,2,3.
    do_reset();
    set_req(0, 1'b1, 8'h10, 32'h0);
    set_req(1, 1'b0, 8'h20, 32'h1111_0001);
    set_req(2, 1'b1, 8'h30, 32'h0);
    set_req(3, 1'b0, 8'hEE, 32'h2222_0003);
    expect_txn(1'b1, 8'h10, 32'h0,         4'b0001, 32'hA5A5_A510);
    expect_txn(1'b0, 8'h20, 32'h1111_0001, 4'b0010, 32'h0);
    expect_txn(1'b1, 8'h30, 32'h0,         4'b0100, 32'hA5A5_A530);
    expect_txn(1'b0, 8'hEE, 32'h2222_0003, 4'b1000, 32'd2);
    pulse(4'b1111);
    wait_drain("simultaneous", 120);

    // Fairness: 0 re-requests right after its completion, 3 is served first.
    set_req(0, 1'b1, 8'h40, 32'h0);
    set_req(3, 1'b1, 8'h43, 32'h0);
    expect_txn(1'b1, 8'h40, 32'h0, 4'b0001, 32'hA5A5_A540);
    expect_txn(1'b1, 8'h43, 32'h0, 4'b1000, 32'hA5A5_A543);
    expect_txn(1'b1, 8'h41, 32'h0, 4'b0001, 32'hA5A5_A541);
    pulse(4'b1001);
    wait_rsp("fair_first", 4'b0001, 40);
    @(negedge clk);
    set_req(0, 1'b1, 8'h41, 32'h0);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    wait_drain("fairness", 120);

    // Busy drop: requester 1 waits behind 3, its second pulse must be ignored.
    set_req(3, 1'b0, 8'h77, 32'hCAFE_0003);
    expect_txn(1'b0, 8'h77, 32'hCAFE_0003, 4'b1000, 32'h0);
    expect_txn(1'b1, 8'h11, 32'h0000_1111, 4'b0010, 32'hA5A5_A511);
    pulse(4'b1000);
    set_req(1, 1'b1, 8'h11, 32'h0000_1111);
    pulse(4'b0010);
    @(negedge clk);
    chk("busy1_set", req_busy[1], 1);
    set_req(1, 1'b0, 8'hAA, 32'h9999_9999);
    pulse(4'b0010);
    wait_drain("busy_drop", 120);

    // Spurious C_out_valid in IDLE: no response, rsp_data holds.
    spur_cnt++;
    repeat (5) @(negedge clk);
    chk("spurious_rsp_data_hold", rsp_data, 32'hA5A5_A511);
    chk("spurious_busy", req_busy, 0);
    set_req(2, 1'b1, 8'h22, 32'h0);
    expect_txn(1'b1, 8'h22, 32'h0, 4'b0100, 32'hA5A5_A522);
    pulse(4'b0100);
    wait_drain("after_spurious", 40);

    // Reset during WAIT with rr_ptr = 3 and three slots busy.
    bridge_lat = 20;
    set_req(0, 1'b1, 8'h50, 32'h0);
    set_req(1, 1'b1, 8'h51, 32'h0);
    set_req(3, 1'b1, 8'h53, 32'h0);
    cmd_q.push_back('{1'b1, 8'h53, 32'h0});
    pulse(4'b1011);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", req_busy, 4'b1011);
    chk("pre_reset_cmd_issued", cmd_q.size(), 0);
    do_reset();
    @(negedge clk);
    check_zero("post_reset");
    bridge_lat = 5;
    repeat (30) @(negedge clk);
    chk("post_reset_idle_busy", req_busy, 0);
    set_req(1, 1'b1, 8'h61, 32'h0);
    set_req(3, 1'b1, 8'h63, 32'h0);
    expect_txn(1'b1, 8'h61, 32'h0, 4'b0010, 32'hA5A5_A561);
    expect_txn(1'b1, 8'h63, 32'h0, 4'b1000, 32'hA5A5_A563);
    pulse(4'b1010);
    wait_drain("post_reset_rotation", 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
